// File: rtl/burst_scheduler_if.sv
// Burst handshake between the scheduler (master) and the memory arbitrator (slave).
interface burst_scheduler_if #(
    parameter int NUM_CHANNELS = 8,
    parameter int BURST_LEN    = 16
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int LW = $clog2(BURST_LEN) + 1;

    logic          burst_req;
    logic [CW-1:0] burst_chan;
    logic [LW-1:0] burst_len;
    logic          burst_ack;
    logic          burst_done;

    modport master (
        output burst_req,
        output burst_chan,
        output burst_len,
        input  burst_ack,
        input  burst_done
    );

    modport slave (
        input  burst_req,
        input  burst_chan,
        input  burst_len,
        output burst_ack,
        output burst_done
    );
endinterface

// File: rtl/burst_scheduler.sv
// Round-robin burst scheduler: grants one FIFO channel at a time a burst of up to
// BURST_LEN bytes over a req/ack/done handshake and keeps per-channel byte counts.
module burst_scheduler #(
    parameter int NUM_CHANNELS = 8,
    parameter int LEVEL_WIDTH  = 12,
    parameter int BURST_LEN    = 16,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [NUM_CHANNELS*LEVEL_WIDTH-1:0] chan_level,
    input  logic [NUM_CHANNELS-1:0]             chan_flush,
    input  logic [NUM_CHANNELS-1:0]             count_clear,
    burst_scheduler_if.master                   bus,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] byte_count,
    output logic                                busy
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int LW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        ACTIVE   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]          last_grant;
    logic [CW-1:0]          chan_q;
    logic [LW-1:0]          len_q;
    logic                   req_q;
    logic [COUNT_WIDTH-1:0] count_q [NUM_CHANNELS];

    logic                   eligible  [NUM_CHANNELS];
    logic [LW-1:0]          grant_len [NUM_CHANNELS];
    logic                   found;
    logic [CW-1:0]          win_chan;
    logic [LW-1:0]          win_len;
    int                     idx;

    function automatic logic [LW-1:0] clip_len(input logic [LEVEL_WIDTH-1:0] level);
        if (level >= LEVEL_WIDTH'(BURST_LEN))
            return LW'(BURST_LEN);
        else
            return level[LW-1:0];
    endfunction

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
        logic [LEVEL_WIDTH-1:0] lvl;
        assign lvl          = chan_level[k*LEVEL_WIDTH +: LEVEL_WIDTH];
        assign eligible[k]  = (lvl >= LEVEL_WIDTH'(BURST_LEN)) || (chan_flush[k] && (lvl != '0));
        assign grant_len[k] = clip_len(lvl);
        assign byte_count[k*COUNT_WIDTH +: COUNT_WIDTH] = count_q[k];
    end

    // Search starts one past the last granted channel and wraps once.
    always_comb begin
        found    = 1'b0;
        win_chan = '0;
        win_len  = '0;
        idx      = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx = int'(last_grant) + 1 + i;
            if (idx >= NUM_CHANNELS)
                idx = idx - NUM_CHANNELS;
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                win_chan = CW'(idx);
                win_len  = grant_len[idx];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (enable && found) next_state = REQUEST;
            REQUEST:  if (bus.burst_ack) next_state = bus.burst_done ? COMPLETE : ACTIVE;
            ACTIVE:   if (bus.burst_done) next_state = COMPLETE;
            COMPLETE: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q      <= 1'b0;
            busy       <= 1'b0;
            chan_q     <= '0;
            len_q      <= '0;
            last_grant <= CW'(NUM_CHANNELS - 1);
        end else begin
            req_q <= (next_state == REQUEST);
            busy  <= (next_state != IDLE);
            if (state == IDLE && next_state == REQUEST) begin
                chan_q <= win_chan;
                len_q  <= win_len;
            end
            if (state == COMPLETE)
                last_grant <= chan_q;
        end
    end

    // A clear in the same cycle as the COMPLETE increment discards that burst's bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CHANNELS; k++)
                count_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (count_clear[k])
                    count_q[k] <= '0;
                else if (state == COMPLETE && chan_q == CW'(k))
                    count_q[k] <= count_q[k] + COUNT_WIDTH'(len_q);
            end
        end
    end

    assign bus.burst_req  = req_q;
    assign bus.burst_chan = chan_q;
    assign bus.burst_len  = len_q;
endmodule

// File: doc/burst_scheduler.md
# burst_scheduler

Parametrised round-robin burst scheduler between the per-port tracking FIFOs and the memory arbitrator. It watches the transferable byte level of `NUM_CHANNELS` FIFOs and grants one channel at a time a burst of at most `BURST_LEN` bytes through a req/ack/done handshake. It keeps a per-channel running byte count of the bytes actually transferred. It replaces the fixed 8-port polling and the separate hand-written byte counters at top level, and adds a flush mode for partial bursts and per-channel count clearing.

## Interface
Parameters:
- `NUM_CHANNELS`, 8, number of FIFO channels (≥2)
- `LEVEL_WIDTH`, 12, width of each channel level field
- `BURST_LEN`, 16, maximum bytes per burst (power of 2, ≥2)
- `COUNT_WIDTH`, 32, width of each byte counter
- Derived: `CW` = clog2(`NUM_CHANNELS`); `LW` = clog2(`BURST_LEN`)+1

Ports:
- `clk`  in  1  single clock for all logic
- `reset`  in  1  asynchronous, active-high
- `enable`  in  1  allows new grants
- `chan_level`  in  NUM_CHANNELS*LEVEL_WIDTH  bytes transferable per channel; channel k occupies bits [k*LEVEL_WIDTH +: LEVEL_WIDTH]
- `chan_flush`  in  NUM_CHANNELS  permits a partial burst on that channel
- `count_clear`  in  NUM_CHANNELS  synchronous clear of that channel's byte count
- `burst_req`  out  1  burst request to the arbitrator
- `burst_chan`  out  CW  granted channel
- `burst_len`  out  LW  burst length in bytes, 1..BURST_LEN
- `burst_ack`  in  1  arbitrator accepted the request
- `burst_done`  in  1  arbitrator finished the burst
- `byte_count`  out  NUM_CHANNELS*COUNT_WIDTH  bytes transferred per channel, packed like `chan_level`
- `busy`  out  1  high in every state except IDLE

## Operation
- Eligibility of channel k: `level_k` ≥ BURST_LEN, or (`chan_flush[k]` and `level_k` > 0).
- Grant length: min(`level_k`, BURST_LEN).
- Arbitration is round-robin. Search begins at `last_grant`+1 modulo NUM_CHANNELS. The first eligible channel wins. `last_grant` resets to NUM_CHANNELS-1, so channel 0 has first priority after reset.
- States:
  - IDLE: if `enable` is high and any channel is eligible, latch the winner and its length, then go to REQUEST.
  - REQUEST: `burst_req`=1. On `burst_ack`, go to ACTIVE. If `burst_ack` and `burst_done` arrive in the same cycle, go straight to COMPLETE.
  - ACTIVE: wait for `burst_done`, then go to COMPLETE.
  - COMPLETE: add the latched length to `byte_count[chan]`, set `last_grant`=chan, then go to IDLE.
- `burst_chan` and `burst_len` are registered. They hold stable from REQUEST entry until COMPLETE exits.
- `burst_done` is ignored in IDLE and in REQUEST without `burst_ack`. `burst_ack` is ignored outside REQUEST.
- Dropping `enable` never aborts a burst. It only blocks the next IDLE→REQUEST transition. A request already in REQUEST stays up until acked.
- `chan_level` and `chan_flush` are sampled only in IDLE. Changes during a burst do not affect the latched length.
- Byte counters wrap modulo 2^COUNT_WIDTH with no saturation. The add uses the zero-extended length.
- If `count_clear[k]` and a COMPLETE increment of channel k occur in the same cycle, the clear wins and the counter becomes 0; the burst's bytes are lost from the count.

## Timing
- Reset values: `burst_req`=0, `burst_chan`=0, `burst_len`=0, `busy`=0, every `byte_count` field=0, state=IDLE, `last_grant`=NUM_CHANNELS-1.
- Reset mid-burst returns immediately to IDLE and clears everything above. The arbitrator must also be reset.
- Request latency: eligibility seen in IDLE in cycle n gives `burst_req`=1 in cycle n+1.
- Completion: `burst_done` in cycle m gives state COMPLETE in cycle m+1, `byte_count` updated and visible in m+2, IDLE in m+2.
- Earliest next request is m+3. The minimum spacing between grants is therefore 3 cycles after done.
- All outputs are registered. `busy` is a registered decode of state.

## Test plan
- Single channel: `level_2`=20, others 0, `enable`=1 → `burst_req` one cycle later with `burst_chan`=2, `burst_len`=16. Ack, then done → `byte_count[2]`=16.
- Round-robin: all eight levels =100; ack/done each request immediately → grant order 0,1,…,7,0. Each count +16 per grant.
- Flush: `level_5`=3, `chan_flush[5]`=0 → no request for 50 cycles. Raise `chan_flush[5]` → `burst_chan`=5, `burst_len`=3.
- Clear collision: `count_clear[1]` asserted in the COMPLETE cycle of a channel-1 burst → `byte_count[1]`=0. Other counters are unaffected.
- Wrap and handshake edge: COUNT_WIDTH=8, preload via 16 bursts of 16 bytes → `byte_count[0]` wraps to 0. Drive ack and done in the same cycle → no ACTIVE state is visited and the count still increments.
- Reset mid-burst: assert `reset` while in ACTIVE → `burst_req`=0, `busy`=0, counts 0 in the same cycle. After release, the next grant goes to channel 0.
